// File: rtl/ysyx_22041752_pkg.sv
// Shared types for the commit trace controller: FSM states and the
// trace-entry layout carried through the FIFO.
package ysyx_22041752_pkg;

  typedef enum logic [1:0] {
    TRC_RUN    = 2'd0,
    TRC_DRAIN  = 2'd1,
    TRC_HALTED = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        exp;
    logic        mret;
    logic        rf_wen;
    logic [4:0]  rf_wnum;
    logic [63:0] rf_wdata;
  } trace_entry_t;

endpackage

// File: rtl/ysyx_22041752_trace_fifo.sv
// Parametric synchronous FIFO; the caller must not push when full
// unless it pops in the same cycle.
module ysyx_22041752_trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_comb begin
    wptr_d = push_i ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop_i  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/ysyx_22041752_trace_ctrl.sv
// Commit trace controller: queues writeback commits for a trace consumer,
// drains and halts on stop. YSYX_22041752_TRACE_PERF_EN adds perf counters.
module ysyx_22041752_trace_ctrl
  import ysyx_22041752_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ws_valid,
  input  logic [63:0]            ws_pc,
  input  logic [31:0]            ws_inst,
  input  logic                   ws_exp,
  input  logic                   ws_mret,
  input  logic                   ws_stop,
  input  logic                   ws_rf_wen,
  input  logic [4:0]             ws_rf_wnum,
  input  logic [63:0]            ws_rf_wdata,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output logic [63:0]            trc_pc,
  output logic [31:0]            trc_inst,
  output logic                   trc_exp,
  output logic                   trc_mret,
  output logic                   trc_rf_wen,
  output logic [4:0]             trc_rf_wnum,
  output logic [63:0]            trc_rf_wdata,
  output logic                   halted,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] fifo_cnt
`ifdef YSYX_22041752_TRACE_PERF_EN
  ,
  output logic [63:0]            perf_cycle,
  output logic [63:0]            perf_instret
`endif
);

  localparam int W = $bits(trace_entry_t);

  trace_state_e state_q;
  logic         halted_q, ovf_q;
  trace_entry_t wr_e, rd_e;
  logic [W-1:0] rdata;
  logic         full, empty, pop, push, drop, in_run;

  assign wr_e = '{pc: ws_pc, inst: ws_inst, exp: ws_exp,
                  mret: ws_mret, rf_wen: ws_rf_wen,
                  rf_wnum: ws_rf_wnum, rf_wdata: ws_rf_wdata};

  assign in_run = (state_q == TRC_RUN);
  assign pop    = trc_valid & trc_ready;
  assign push   = ws_valid & in_run & ~reset & (~full | pop);
  assign drop   = ws_valid & in_run & full & ~pop;

  ysyx_22041752_trace_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_e),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= TRC_RUN;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        TRC_RUN: begin
          if (drop) ovf_q <= 1'b1;
          if ((push | drop) & ws_stop) state_q <= TRC_DRAIN;
        end
        TRC_DRAIN: begin
          if (empty) begin
            state_q  <= TRC_HALTED;
            halted_q <= 1'b1;
          end
        end
        TRC_HALTED: state_q <= TRC_HALTED;
        default: begin
          state_q  <= TRC_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef YSYX_22041752_TRACE_PERF_EN
  logic [63:0] cyc_q, ret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else if (in_run) begin
      cyc_q <= cyc_q + 64'd1;
      if (push & ~ws_exp) ret_q <= ret_q + 64'd1;
    end
  end

  assign perf_cycle   = cyc_q;
  assign perf_instret = ret_q;
`endif

  assign rd_e         = rdata;
  assign trc_valid    = ~empty;
  assign trc_pc       = rd_e.pc;
  assign trc_inst     = rd_e.inst;
  assign trc_exp      = rd_e.exp;
  assign trc_mret     = rd_e.mret;
  assign trc_rf_wen   = rd_e.rf_wen;
  assign trc_rf_wnum  = rd_e.rf_wnum;
  assign trc_rf_wdata = rd_e.rf_wdata;
  assign halted       = halted_q;
  assign ovf          = ovf_q;

endmodule
